approx_mul_err_sweep: RTL and testbench

Self-checking characterisation engine wrapped around the 4x4 approximate multiplier. It drives all 256 operand pairs into the multiplier's A/B inputs and consumes the 8-bit result. It compares each result against an internally computed exact product and accumulates the error metrics: error count, sum of error distances and maximum error distance. It sits directly upstream and downstream of the multiplier, which connects between mul_a/mul_b and mul_result.

---
 rtl/approx_mul_err_sweep_if.sv | 36 +++
 rtl/approx_mul_err_sweep.sv | 162 ++++++++++++++++
 tb/tb_approx_mul_err_sweep.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mul_err_sweep_if.sv
// Control/status and multiplier-side bundle for the error sweep engine.
// max_a/max_b exist only when APPROX_ERR_LOC_EN is defined.
interface approx_mul_err_sweep_if #(
    parameter int ACC_W = 16
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [3:0]       mul_a;
    logic [3:0]       mul_b;
    logic [7:0]       mul_result;
    logic [8:0]       err_count;
    logic [ACC_W-1:0] sum_err;
    logic [7:0]       max_err;
`ifdef APPROX_ERR_LOC_EN
    logic [3:0]       max_a;
    logic [3:0]       max_b;
`endif

    modport master (
        output start, abort, mul_result,
        input  busy, done, mul_a, mul_b, err_count, sum_err, max_err
`ifdef APPROX_ERR_LOC_EN
        , max_a, max_b
`endif
    );

    modport slave (
        input  start, abort, mul_result,
        output busy, done, mul_a, mul_b, err_count, sum_err, max_err
`ifdef APPROX_ERR_LOC_EN
        , max_a, max_b
`endif
    );
endinterface

// File: rtl/approx_mul_err_sweep.sv
// Sweeps all 256 4x4 operand pairs through an external multiplier and
// accumulates error stats; APPROX_ERR_LOC_EN adds max-error location.
module approx_mul_err_sweep #(
    parameter int ACC_W   = 16,
    parameter int MUL_LAT = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    approx_mul_err_sweep_if.slave bus
);
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state_q, state_d;
    logic [8:0]       issue_q;
    logic [7:0]       samp_q;
    logic [3:0]       a_q, b_q;
    logic [7:0]       exp_q [MUL_LAT+1];
    logic [MUL_LAT:0] v_q;
    logic [8:0]       err_q;
    logic [ACC_W-1:0] sum_q;
    logic [7:0]       max_q;
    logic             done_q;

    logic             busy, go, flush, acc, fin, v_al;
    logic [7:0]       e_al, prod, diff;
    logic [8:0]       dsig;
    logic [ACC_W:0]   sum_nx;

    assign v_al   = v_q[MUL_LAT];
    assign e_al   = exp_q[MUL_LAT];
    assign fin    = v_al && (samp_q == 8'd255);
    assign prod   = {4'd0, issue_q[7:4]} * {4'd0, issue_q[3:0]};
    assign dsig   = {1'b0, bus.mul_result} - {1'b0, e_al};
    assign diff   = dsig[8] ? 8'(~dsig + 9'd1) : dsig[7:0];
    assign sum_nx = {1'b0, sum_q} + {{(ACC_W-7){1'b0}}, diff};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: start wins in IDLE, abort wins in SWEEP
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.start) state_d = SWEEP;
            SWEEP: if (bus.abort || fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and per-cycle strobes
    always_comb begin
        busy  = (state_q == SWEEP);
        go    = !busy && bus.start;
        flush = busy && (bus.abort || fin);
        acc   = busy && !bus.abort && v_al;
    end

    // Operand issue and expected-product alignment pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            v_q     <= '0;
            for (int i = 0; i <= MUL_LAT; i++) exp_q[i] <= '0;
        end else if (go) begin
            issue_q <= 9'd1;
            a_q     <= '0;
            b_q     <= '0;
            v_q     <= (MUL_LAT+1)'(1);
            for (int i = 0; i <= MUL_LAT; i++) exp_q[i] <= '0;
        end else if (flush || !busy) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= '0;
        end else begin
            for (int i = 1; i <= MUL_LAT; i++) begin
                v_q[i]   <= v_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
            if (!issue_q[8]) begin
                a_q      <= issue_q[7:4];
                b_q      <= issue_q[3:0];
                exp_q[0] <= prod;
                v_q[0]   <= 1'b1;
                issue_q  <= issue_q + 9'd1;
            end else begin
                v_q[0] <= 1'b0;
            end
        end
    end

`ifdef APPROX_ERR_LOC_EN
    logic [7:0] loc_q [MUL_LAT+1];
    logic [3:0] ma_q, mb_q;

    // Pair index travelling alongside the expected product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= MUL_LAT; i++) loc_q[i] <= '0;
        end else begin
            for (int i = 1; i <= MUL_LAT; i++) loc_q[i] <= loc_q[i-1];
            if (go)                         loc_q[0] <= '0;
            else if (busy && !issue_q[8])   loc_q[0] <= issue_q[7:0];
        end
    end

    // Location of the first sample reaching the maximum error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || 1'b0) begin
            ma_q <= '0;
            mb_q <= '0;
        end else if (go) begin
            ma_q <= '0;
            mb_q <= '0;
        end else if (acc && (diff > max_q)) begin
            ma_q <= loc_q[MUL_LAT][7:4];
            mb_q <= loc_q[MUL_LAT][3:0];
        end
    end

    assign bus.max_a = ma_q;
    assign bus.max_b = mb_q;
`endif

    // Error statistics, cleared on start and held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= '0;
            sum_q  <= '0;
            max_q  <= '0;
            samp_q <= '0;
        end else if (go) begin
            err_q  <= '0;
            sum_q  <= '0;
            max_q  <= '0;
            samp_q <= '0;
        end else if (acc) begin
            samp_q <= samp_q + 8'd1;
            if (diff != 8'd0) err_q <= err_q + 9'd1;
            sum_q <= sum_nx[ACC_W] ? '1 : sum_nx[ACC_W-1:0];
            if (diff > max_q) max_q <= diff;
        end
    end

    // One-cycle completion pulse after the final sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= acc && fin;
    end

    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.err_count = err_q;
    assign bus.sum_err   = sum_q;
    assign bus.max_err   = max_q;
endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// Bench: three engines (exact/zero/LSB-drop multipliers, ACC_W 16/12,
// MUL_LAT 0/0/2) checked every cycle against a pair-index model.
module tb_approx_mul_err_sweep;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   mode = 0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    approx_mul_err_sweep_if #(.ACC_W(16)) i0 ();
    approx_mul_err_sweep_if #(.ACC_W(12)) i1 ();
    approx_mul_err_sweep_if #(.ACC_W(16)) i2 ();

    approx_mul_err_sweep #(.ACC_W(16), .MUL_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(i0));
    approx_mul_err_sweep #(.ACC_W(12), .MUL_LAT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(i1));
    approx_mul_err_sweep #(.ACC_W(16), .MUL_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(i2));

    // multiplier stand-ins: 0 exact, 1 tied to zero, 2 product with bit0 dropped
    function automatic int f(input int md, input int a, input int b);
        if (md == 0)      return a * b;
        else if (md == 1) return 0;
        else              return (a * b) & 254;
    endfunction

    assign i0.start = start;
    assign i1.start = start;
    assign i2.start = start;
    assign i0.abort = abort;
    assign i1.abort = abort;
    assign i2.abort = abort;
    assign i0.mul_result = 8'(f(mode, int'(i0.mul_a), int'(i0.mul_b)));
    assign i1.mul_result = 8'(f(mode, int'(i1.mul_a), int'(i1.mul_b)));

    logic [7:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= 8'(f(mode, int'(i2.mul_a), int'(i2.mul_b)));
        p2 <= p1;
    end
    assign i2.mul_result = p2;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: cycle index since start edge determines pair shown and sampled
    int lat[3] = '{0, 0, 2};
    int sat[3] = '{65535, 4095, 65535};
    int m_busy[3], m_cyc[3], m_done[3], m_err[3];
    int m_sum[3], m_max[3], m_ma[3], m_mb[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 3; j++) begin
                m_busy[j] <= 0; m_cyc[j] <= 0; m_done[j] <= 0; m_err[j] <= 0;
                m_sum[j] <= 0; m_max[j] <= 0; m_ma[j] <= 0; m_mb[j] <= 0;
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                int by, cy, dn, er, sm, mx, ma, mb, k, a, b, d;
                by = m_busy[j]; cy = m_cyc[j]; dn = 0; er = m_err[j];
                sm = m_sum[j]; mx = m_max[j]; ma = m_ma[j]; mb = m_mb[j];
                if (by == 0) begin
                    if (start) begin
                        by = 1; cy = 0; er = 0; sm = 0; mx = 0; ma = 0; mb = 0;
                    end
                end else if (abort) begin
                    by = 0;
                end else begin
                    cy++;
                    if (cy >= 1 + lat[j] && cy <= 256 + lat[j]) begin
                        k = cy - 1 - lat[j];
                        a = k / 16;
                        b = k % 16;
                        d = f(mode, a, b) - a * b;
                        if (d < 0) d = -d;
                        if (d != 0) er++;
                        sm = sm + d;
                        if (sm > sat[j]) sm = sat[j];
                        if (d > mx) begin mx = d; ma = a; mb = b; end
                        if (cy == 256 + lat[j]) begin by = 0; dn = 1; end
                    end
                end
                m_busy[j] <= by; m_cyc[j] <= cy; m_done[j] <= dn; m_err[j] <= er;
                m_sum[j] <= sm; m_max[j] <= mx; m_ma[j] <= ma; m_mb[j] <= mb;
            end
        end
    end

    function automatic int exp_op(input int j, input int hi);
        int p;
        if (m_busy[j] == 0) return 0;
        p = (m_cyc[j] <= 255) ? m_cyc[j] : 255;
        return hi ? p / 16 : p % 16;
    endfunction

    task automatic chk_dut(input int j, input int by, input int dn,
                           input int ma, input int mb, input int er,
                           input int sm, input int mx, input int la, input int lb);
        string s;
        s = $sformatf("dut%0d", j);
        chk({s, " busy"}, by, m_busy[j]);
        chk({s, " done"}, dn, m_done[j]);
        chk({s, " mul_a"}, ma, exp_op(j, 1));
        chk({s, " mul_b"}, mb, exp_op(j, 0));
        chk({s, " err_count"}, er, m_err[j]);
        chk({s, " sum_err"}, sm, m_sum[j]);
        chk({s, " max_err"}, mx, m_max[j]);
`ifdef APPROX_ERR_LOC_EN
        chk({s, " max_a"}, la, m_ma[j]);
        chk({s, " max_b"}, lb, m_mb[j]);
`else
        if (la != 0 || lb != 0) chk({s, " loc"}, la + lb, 0);
`endif
    endtask

    // per-cycle comparison of all three engines against the model
    always @(negedge clk) begin
`ifdef APPROX_ERR_LOC_EN
        chk_dut(0, i0.busy, i0.done, i0.mul_a, i0.mul_b, i0.err_count,
                i0.sum_err, i0.max_err, i0.max_a, i0.max_b);
        chk_dut(1, i1.busy, i1.done, i1.mul_a, i1.mul_b, i1.err_count,
                i1.sum_err, i1.max_err, i1.max_a, i1.max_b);
        chk_dut(2, i2.busy, i2.done, i2.mul_a, i2.mul_b, i2.err_count,
                i2.sum_err, i2.max_err, i2.max_a, i2.max_b);
`else
        chk_dut(0, i0.busy, i0.done, i0.mul_a, i0.mul_b, i0.err_count,
                i0.sum_err, i0.max_err, 0, 0);
        chk_dut(1, i1.busy, i1.done, i1.mul_a, i1.mul_b, i1.err_count,
                i1.sum_err, i1.max_err, 0, 0);
        chk_dut(2, i2.busy, i2.done, i2.mul_a, i2.mul_b, i2.err_count,
                i2.sum_err, i2.max_err, 0, 0);
`endif
    end

    // busy/done cycle counters sampled mid-high-phase
    int bc[3] = '{0, 0, 0};
    int dc[3] = '{0, 0, 0};
    always @(posedge clk) begin
        #3;
        if (i0.busy) bc[0]++;
        if (i2.busy) bc[2]++;
        if (i0.done) dc[0]++;
        if (i2.done) dc[2]++;
    end

    task automatic run_full(input int extra_at);
        int b0, b2, d0, d2;
        bit seen;
        b0 = bc[0]; b2 = bc[2]; d0 = dc[0]; d2 = dc[2];
        seen = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 400 && !seen; c++) begin
            @(negedge clk);
            start = (c == extra_at);
            if (i2.done) seen = 1'b1;
        end
        start = 1'b0;
        chk("sweep completes in budget", int'(seen), 1);
        repeat (2) @(negedge clk);
        chk("busy cycles lat0", bc[0] - b0, 256);
        chk("busy cycles lat2", bc[2] - b2, 258);
        chk("done cycles lat0", dc[0] - d0, 1);
        chk("done cycles lat2", dc[2] - d2, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk("reset busy", i0.busy, 0);
        chk("reset err_count", i1.err_count, 0);
        chk("reset mul_a", i2.mul_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mode = 0;
        run_full(0);
        chk("exact err_count", i0.err_count, 0);
        chk("exact sum_err", i0.sum_err, 0);
        chk("exact max_err", i0.max_err, 0);
        chk("exact lat2 err_count", i2.err_count, 0);

        mode = 1;
        run_full(0);
        chk("zero err_count", i0.err_count, 225);
        chk("zero sum_err", i0.sum_err, 14400);
        chk("zero max_err", i0.max_err, 225);
        chk("zero acc12 sum_err", i1.sum_err, 4095);
        chk("zero acc12 err_count", i1.err_count, 225);
        chk("zero lat2 sum_err", i2.sum_err, 14400);
`ifdef APPROX_ERR_LOC_EN
        chk("zero max_a", i0.max_a, 15);
        chk("zero max_b", i0.max_b, 15);
`endif

        mode = 2;
        run_full(50);
        chk("lsb err_count", i0.err_count, 64);
        chk("lsb sum_err", i0.sum_err, 64);
        chk("lsb max_err", i0.max_err, 1);
`ifdef APPROX_ERR_LOC_EN
        chk("lsb max_a", i0.max_a, 1);
        chk("lsb max_b", i0.max_b, 1);
`endif

        mode = 1;
        d0 = dc[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy lat0", i0.busy, 0);
        chk("abort busy lat2", i2.busy, 0);
        chk("abort done", i0.done, 0);
        chk("abort err_count lat0", i0.err_count, 78);
        chk("abort sum_err lat0", i0.sum_err, 1836);
        chk("abort max_err lat0", i0.max_err, 75);
        chk("abort err_count lat2", i2.err_count, 76);
        repeat (4) @(negedge clk);
        chk("abort no done pulse", dc[0] - d0, 0);
        chk("abort stats hold", i0.err_count, 78);

        d0 = dc[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset busy", i0.busy, 0);
        chk("mid reset mul_b", i0.mul_b, 0);
        chk("mid reset err_count", i0.err_count, 0);
        chk("mid reset sum_err", i0.sum_err, 0);
        chk("mid reset max_err", i2.max_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid reset no done", dc[0] - d0, 0);

        mode = 0;
        run_full(0);
        chk("post reset err_count", i0.err_count, 0);
        chk("post reset sum_err", i2.sum_err, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
